sepn_snap: RTL and testbench
============================

SEPN_SNAP -- requirements
Module: sepn_snap

Interface
REQ-001 Parameter WIDTH, default 10: sample width in bits.
REQ-002 Parameter SLOTS, default 32: slots per frame; power of two, 8..32; AW = log2(SLOTS).
REQ-003 Parameter STG, default 0: pipeline stage of `mixed`; range 0..SLOTS-1.
REQ-004 Port clk  input  1  clock, all logic on rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port cen  input  1  clock enable; state advances only when high, except where stated.
REQ-007 Port mixed  input  WIDTH  time-multiplexed sample.
REQ-008 Port cnt  input  AW  slot counter of the multiplexed stream.
REQ-009 Port live  output  SLOTS*WIDTH  per-slot latest sample; slot k occupies bits [k*WIDTH +: WIDTH].
REQ-010 Port snap_req  input  1  level request for a coherent full-frame snapshot.
REQ-011 Port snap_busy  output  1  high in ARM or CAPTURE.
REQ-012 Port snap_done  output  1  one-clk pulse when the snapshot completes.
REQ-013 Port snap_err  output  1  sticky counter-discontinuity flag.
REQ-014 Port rd_addr  input  AW  snapshot read slot index.
REQ-015 Port rd_data  output  WIDTH  snapshot[rd_addr], registered.

Function
REQ-016 Slot index adj = (cnt + SLOTS + 1 - STG) mod SLOTS, computed combinationally, AW bits.
REQ-017 On each cen cycle, live slot adj SHALL load `mixed`; all other live slots hold.
REQ-018 The FSM SHALL have states IDLE, ARM, CAPTURE, DONE.
REQ-019 IDLE -> ARM when snap_req=1 (cen not required); snap_req in any other state is ignored.
REQ-020 ARM -> CAPTURE on a cen cycle with adj=0; that sample is written to snapshot slot 0.
REQ-021 In CAPTURE, each cen cycle SHALL write `mixed` to snapshot slot adj.
REQ-022 CAPTURE -> DONE on the cen cycle that writes slot SLOTS-1; a capture spans exactly SLOTS cen cycles.
REQ-023 DONE SHALL assert snap_done for one clk, then go to IDLE regardless of cen.
REQ-024 Snapshot contents SHALL change only in CAPTURE (and on reset).
REQ-025 rd_data SHALL equal snapshot[rd_addr] one clk after rd_addr is applied, independent of cen; reads during CAPTURE return the previous or newly written value per slot, never a mix of bits.
REQ-026 snap_busy SHALL be combinational from state: 1 in ARM/CAPTURE, else 0.
REQ-027 cnt wrap from SLOTS-1 to 0 SHALL be treated as normal succession.

Reset
REQ-028 rst_n=0 SHALL, asynchronously: state=IDLE; live, snapshot and rd_data all zero; snap_done=0; snap_err=0.
REQ-029 Reset during ARM or CAPTURE SHALL abort the capture without a snap_done pulse.

Configuration
REQ-030 Macro SEPN_SNAP_CHK_EN SHALL enable counter-continuity checking.
REQ-031 With SEPN_SNAP_CHK_EN defined: in CAPTURE, if adj on a cen cycle differs from (previous adj + 1) mod SLOTS, then set snap_err, discard the sample, and return to ARM without snap_done.
REQ-032 With SEPN_SNAP_CHK_EN defined: snap_err SHALL clear on the IDLE->ARM transition.
REQ-033 Without SEPN_SNAP_CHK_EN: snap_err is tied 0, and CAPTURE writes slot adj on every cen cycle until slot SLOTS-1 is written.

Verification
REQ-034 WIDTH=10, SLOTS=32, STG=0, cnt 0..31 with cen=1, mixed=cnt*3 -> live slot (cnt+1)%32 = cnt*3 one clk later.
REQ-035 snap_req pulse at adj=5 -> ARM until adj=0; snap_done exactly 32 cen cycles later; rd_addr=7 gives rd_data = sample seen at adj=7.
REQ-036 cen toggling 1-of-3 during capture -> snap_done after 32 cen cycles (about 96 clks); snapshot identical to the cen=1 case.
REQ-037 CHK_EN, cnt jumps 10->14 mid-capture -> snap_err=1, state ARM, no snap_done; the next full frame completes with snap_err still 1 until a new snap_req.
REQ-038 rst_n low at capture slot 20 -> immediately IDLE, all rd_data=0, snap_busy=0, no snap_done.
REQ-039 SLOTS=8, STG=3: cnt=2 -> live slot 0 loads (2+8+1-3)%8=0; a snapshot completes in 8 cen cycles.

Source files
------------

// File: rtl/sepn_snap.sv
// sepn_snap: demultiplexes a slot-interleaved sample stream into per-slot
// registers and can freeze one coherent full frame into a readable snapshot.
// Latency: live slot updates 1 clk after its cen cycle; rd_data 1 clk after rd_addr.
// Backpressure: none; the stream is qualified only by cen and cannot be stalled.
//
// Parameters:
//   WIDTH  sample width in bits
//   SLOTS  slots per frame (power of two, 8..32); AW = log2(SLOTS)
//   STG    pipeline stage of `mixed` relative to `cnt` (0..SLOTS-1)
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   cen                 clock enable qualifying mixed/cnt
//   mixed, cnt          multiplexed sample and its slot counter
//   live                all slots' latest samples, slot k at [k*WIDTH +: WIDTH]
//   snap_req            level request for a full-frame snapshot
//   snap_busy           high while waiting for frame start or capturing
//   snap_done           one-clk pulse when a snapshot completes
//   snap_err            sticky counter-discontinuity flag
//   rd_addr, rd_data    registered snapshot read port
//
// Build option: define SEPN_SNAP_CHK_EN to enable counter-continuity checking
// during capture. Without it snap_err is tied low.

module sepn_snap #(
  parameter  int WIDTH = 10,
  parameter  int SLOTS = 32,
  parameter  int STG   = 0,
  localparam int AW    = $clog2(SLOTS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cen,
  input  logic [WIDTH-1:0]       mixed,
  input  logic [AW-1:0]          cnt,
  output logic [SLOTS*WIDTH-1:0] live,
  input  logic                   snap_req,
  output logic                   snap_busy,
  output logic                   snap_done,
  output logic                   snap_err,
  input  logic [AW-1:0]          rd_addr,
  output logic [WIDTH-1:0]       rd_data
);

  // Offset that aligns the counter with the stage of `mixed`. STG <= SLOTS-1
  // keeps the sum positive, and the AW-bit add below wraps modulo SLOTS.
  localparam int OFS = (SLOTS + 1 - STG) % SLOTS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t           r_state;
  logic             r_snap_done;
  logic [WIDTH-1:0] r_live [SLOTS];
  logic [WIDTH-1:0] r_snap [SLOTS];
  logic [WIDTH-1:0] r_rd_data;

  logic [AW-1:0]    w_adj;
  logic             w_last;
  logic             w_seq_ok;
  logic             w_snap_we;

  assign w_adj  = cnt + AW'(OFS);
  assign w_last = (w_adj == AW'(SLOTS - 1));

  // ---------------------------------------------------------------------------
  // Continuity check: in capture, each enabled sample must follow the slot
  // written just before it. r_prev_adj tracks the last slot committed to the
  // snapshot, so a break is detected against what was actually stored.
  // ---------------------------------------------------------------------------
`ifdef SEPN_SNAP_CHK_EN
  logic [AW-1:0] r_prev_adj;
  logic          r_snap_err;

  assign w_seq_ok = (w_adj == AW'(r_prev_adj + AW'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_adj <= '0;
    end else if (w_snap_we) begin
      r_prev_adj <= w_adj;
    end
  end

  // Sticky until the next snapshot is requested, so software can see that a
  // completed frame was preceded by a restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap_err <= 1'b0;
    end else if (r_state == S_IDLE && snap_req) begin
      r_snap_err <= 1'b0;
    end else if (r_state == S_CAPTURE && cen && !w_seq_ok) begin
      r_snap_err <= 1'b1;
    end
  end

  assign snap_err = r_snap_err;
`else
  assign w_seq_ok = 1'b1;
  assign snap_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Live slot registers: every enabled sample lands in its own slot.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SLOTS; k++) begin
        r_live[k] <= '0;
      end
    end else if (cen) begin
      r_live[w_adj] <= mixed;
    end
  end

  for (genvar g = 0; g < SLOTS; g++) begin : g_live
    assign live[g*WIDTH +: WIDTH] = r_live[g];
  end

  // ---------------------------------------------------------------------------
  // Snapshot write enable. Capture starts only at a frame boundary (slot 0)
  // so the stored frame is coherent; a discontinuous sample is never stored.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_snap_we = 1'b0;
    case (r_state)
      S_ARM:     w_snap_we = cen && (w_adj == '0);
      S_CAPTURE: w_snap_we = cen && w_seq_ok;
      default:   w_snap_we = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Snapshot control FSM with registered done pulse. The pulse is raised on
  // entry to DONE so it is high for exactly the one clk spent there.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_snap_done <= 1'b0;
    end else begin
      r_snap_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (snap_req) begin
            r_state <= S_ARM;
          end
        end
        S_ARM: begin
          if (w_snap_we) begin
            r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (cen) begin
            if (!w_seq_ok) begin
              // Restart on the next frame boundary; no done pulse.
              r_state <= S_ARM;
            end else if (w_last) begin
              r_state     <= S_DONE;
              r_snap_done <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Snapshot storage and registered read port. Each slot is written whole in
  // one clk, so a concurrent read returns either the old or the new word.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SLOTS; k++) begin
        r_snap[k] <= '0;
      end
    end else if (w_snap_we) begin
      r_snap[w_adj] <= mixed;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_snap[rd_addr];
    end
  end

  assign rd_data   = r_rd_data;
  assign snap_done = r_snap_done;
  assign snap_busy = (r_state == S_ARM) || (r_state == S_CAPTURE);

endmodule

// File: tb/tb_sepn_snap.sv
// Bench for sepn_snap: a default 32-slot instance plus an 8-slot STG=3
// instance. Snapshot read expectations go through a scoreboard queue.

module tb_sepn_snap;

  localparam int W  = 10;
  localparam int S  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cen;
  logic [W-1:0]  mixed;
  logic [AW-1:0] cnt;
  logic [S*W-1:0] live;
  logic          snap_req;
  logic          snap_busy;
  logic          snap_done;
  logic          snap_err;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;

  logic          cen8;
  logic [W-1:0]  mixed8;
  logic [2:0]    cnt8;
  logic [8*W-1:0] live8;
  logic          req8;
  logic          busy8;
  logic          done8;
  logic          err8;
  logic [2:0]    rd_addr8;
  logic [W-1:0]  rd_data8;

  int n_chk  = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  int s_cnt = 0;
  int tag   = 0;
  int drove_adj = 0;

  always #5 clk = ~clk;

  sepn_snap #(.WIDTH(W), .SLOTS(S), .STG(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .mixed(mixed), .cnt(cnt), .live(live),
    .snap_req(snap_req), .snap_busy(snap_busy), .snap_done(snap_done),
    .snap_err(snap_err), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  sepn_snap #(.WIDTH(W), .SLOTS(8), .STG(3)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .cen(cen8), .mixed(mixed8), .cnt(cnt8), .live(live8),
    .snap_req(req8), .snap_busy(busy8), .snap_done(done8),
    .snap_err(err8), .rd_addr(rd_addr8), .rd_data(rd_data8)
  );

  function automatic logic [W-1:0] pat(input int c, input int t);
    return W'((c * 7 + t * 13 + 1) % 1024);
  endfunction

  // One clock of the 32-slot stream; outputs are valid on return (#1 after edge).
  task automatic tick(input logic c_en, input logic req);
    cen      = c_en;
    snap_req = req;
    cnt      = AW'(s_cnt);
    mixed    = c_en ? pat(s_cnt, tag) : W'($urandom);
    drove_adj = (s_cnt + 1) % S;
    @(posedge clk);
    #1;
    if (c_en) s_cnt = (s_cnt + 1) % S;
  endtask

  // Runs the stream (cen every `period` clks) until snap_done, the cycle
  // budget, or the cen cycle that wrote stop_slot.
  task automatic run_capture(input int period, input int stop_slot, input bit counting_in,
                             output int n_cen, output int n_clk, output bit seen);
    bit counting;
    bit en;
    bit start;
    int ph;
    counting = counting_in;
    ph = 0;
    n_cen = 0;
    n_clk = 0;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      en = (ph == 0);
      ph = (ph + 1) % period;
      start = !counting && en && snap_busy && ((s_cnt + 1) % S == 0);
      tick(en, 1'b0);
      if (start) counting = 1'b1;
      if (counting) begin
        n_clk++;
        if (en) n_cen++;
      end
      if (snap_done) begin
        seen = 1'b1;
        break;
      end
      if (counting && en && stop_slot >= 0 && drove_adj == stop_slot) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cen = 1'b0; snap_req = 1'b0; mixed = '0; cnt = '0; rd_addr = '0;
    cen8 = 1'b0; req8 = 1'b0; mixed8 = '0; cnt8 = '0; rd_addr8 = '0;
    #12;
    n_chk++; if (live !== '0) begin n_fail++; $display("FAIL rst_live: got %0h want 0", live); end
    n_chk++; if (rd_data !== '0) begin n_fail++; $display("FAIL rst_rd_data: got %0h want 0", rd_data); end
    n_chk++; if ({snap_busy, snap_done, snap_err} !== 3'b000) begin
      n_fail++; $display("FAIL rst_flags: got %b want 000", {snap_busy, snap_done, snap_err}); end
    n_chk++; if ({busy8, done8, err8} !== 3'b000 || live8 !== '0) begin
      n_fail++; $display("FAIL rst_dut8: got flags %b live %0h want 0", {busy8, done8, err8}, live8); end
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_live();
    for (int c = 0; c < S; c++) begin
      cen = 1'b1; cnt = AW'(c); mixed = W'(c * 3);
      exp_q.push_back(W'(c * 3));
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      n_chk++;
      if (live[((c + 1) % S) * W +: W] !== exp_v) begin
        n_fail++;
        $display("FAIL live_slot%0d: got %0h want %0h", (c + 1) % S, live[((c + 1) % S) * W +: W], exp_v);
      end
    end
    s_cnt = 0;
  endtask

  task automatic test_snapshot();
    int addrs[4] = '{7, 0, 31, 16};
    int nc, nk;
    bit seen;
    tag = 2;
    for (int i = 0; i < S && s_cnt != 4; i++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    n_chk++; if (snap_busy !== 1'b1) begin n_fail++; $display("FAIL snap_arm_busy: got %b want 1", snap_busy); end
    run_capture(1, -1, 1'b0, nc, nk, seen);
    n_chk++; if (!seen) begin n_fail++; $display("FAIL snap_done_timeout: got 0 want 1"); end
    n_chk++; if (nc !== 32) begin n_fail++; $display("FAIL snap_cen_count: got %0d want 32", nc); end
    n_chk++; if (snap_err !== 1'b0) begin n_fail++; $display("FAIL snap_err_clean: got %b want 0", snap_err); end
    tick(1'b0, 1'b0);
    n_chk++; if ({snap_done, snap_busy} !== 2'b00) begin
      n_fail++; $display("FAIL snap_done_pulse: got %b want 00", {snap_done, snap_busy}); end
    foreach (addrs[i]) begin
      rd_addr = AW'(addrs[i]);
      exp_q.push_back(pat((addrs[i] + S - 1) % S, 2));
      tick(1'b0, 1'b0);
      exp_v = exp_q.pop_front();
      n_chk++; if (rd_data !== exp_v) begin
        n_fail++; $display("FAIL snap_rd%0d: got %0h want %0h", addrs[i], rd_data, exp_v); end
    end
  endtask

  task automatic test_abort();
    int nc, nk;
    bit seen;
    bit any_done;
    tag = 11;
    tick(1'b1, 1'b1);
    run_capture(1, 20, 1'b0, nc, nk, seen);
    n_chk++; if (seen || snap_busy !== 1'b1) begin
      n_fail++; $display("FAIL abort_mid_capture: got done %b busy %b want 0 1", seen, snap_busy); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({snap_busy, snap_done, rd_data} !== '0) begin
      n_fail++; $display("FAIL abort_async: got busy %b done %b rd %0h want 0", snap_busy, snap_done, rd_data); end
    n_chk++; if (live !== '0) begin n_fail++; $display("FAIL abort_live: got %0h want 0", live); end
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    any_done = 1'b0;
    for (int a = 0; a < S; a++) begin
      rd_addr = AW'(a);
      exp_q.push_back('0);
      tick(1'b0, 1'b0);
      any_done |= snap_done;
      exp_v = exp_q.pop_front();
      n_chk++; if (rd_data !== exp_v) begin
        n_fail++; $display("FAIL abort_rd%0d: got %0h want %0h", a, rd_data, exp_v); end
    end
    n_chk++; if (any_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got 1 want 0"); end
  endtask

  task automatic test_cen_toggle();
    int addrs[5] = '{7, 0, 31, 16, 1};
    int nc, nk;
    bit seen;
    tag = 2;
    tick(1'b1, 1'b1);
    run_capture(3, -1, 1'b0, nc, nk, seen);
    n_chk++; if (!seen || nc !== 32) begin
      n_fail++; $display("FAIL tog_cen_count: got seen %b cen %0d want 1 32", seen, nc); end
    n_chk++; if (nk < 90 || nk > 98) begin n_fail++; $display("FAIL tog_clks: got %0d want about 94", nk); end
    foreach (addrs[i]) begin
      rd_addr = AW'(addrs[i]);
      exp_q.push_back(pat((addrs[i] + S - 1) % S, 2));
      tick(1'b0, 1'b0);
      exp_v = exp_q.pop_front();
      n_chk++; if (rd_data !== exp_v) begin
        n_fail++; $display("FAIL tog_rd%0d: got %0h want %0h", addrs[i], rd_data, exp_v); end
    end
  endtask

  task automatic test_chk();
    int nc, nk;
    bit seen;
    tag = 4;
    tick(1'b1, 1'b1);
    run_capture(1, 11, 1'b0, nc, nk, seen);
    s_cnt = 14;
    tick(1'b1, 1'b0);
`ifdef SEPN_SNAP_CHK_EN
    n_chk++; if ({snap_err, snap_busy, snap_done} !== 3'b110) begin
      n_fail++; $display("FAIL chk_jump: got err/busy/done %b want 110", {snap_err, snap_busy, snap_done}); end
    run_capture(1, -1, 1'b0, nc, nk, seen);
    n_chk++; if (!seen || nc !== 32 || snap_err !== 1'b1) begin
      n_fail++; $display("FAIL chk_refill: got seen %b cen %0d err %b want 1 32 1", seen, nc, snap_err); end
    rd_addr = AW'(13); exp_q.push_back(pat(12, 4)); tick(1'b0, 1'b0);
    exp_v = exp_q.pop_front();
    n_chk++; if (rd_data !== exp_v) begin n_fail++; $display("FAIL chk_rd13: got %0h want %0h", rd_data, exp_v); end
    rd_addr = AW'(15); exp_q.push_back(pat(14, 4)); tick(1'b0, 1'b0);
    exp_v = exp_q.pop_front();
    n_chk++; if (rd_data !== exp_v) begin n_fail++; $display("FAIL chk_rd15: got %0h want %0h", rd_data, exp_v); end
    n_chk++; if (snap_err !== 1'b1) begin n_fail++; $display("FAIL chk_err_sticky: got %b want 1", snap_err); end
    tick(1'b0, 1'b1);
    n_chk++; if ({snap_err, snap_busy} !== 2'b01) begin
      n_fail++; $display("FAIL chk_err_clear: got err/busy %b want 01", {snap_err, snap_busy}); end
`else
    n_chk++; if ({snap_err, snap_busy, snap_done} !== 3'b010) begin
      n_fail++; $display("FAIL nochk_jump: got err/busy/done %b want 010", {snap_err, snap_busy, snap_done}); end
    run_capture(1, -1, 1'b1, nc, nk, seen);
    n_chk++; if (!seen || nc !== 16 || snap_err !== 1'b0) begin
      n_fail++; $display("FAIL nochk_finish: got seen %b cen %0d err %b want 1 16 0", seen, nc, snap_err); end
    rd_addr = AW'(13); exp_q.push_back(pat(12, 2)); tick(1'b0, 1'b0);
    exp_v = exp_q.pop_front();
    n_chk++; if (rd_data !== exp_v) begin n_fail++; $display("FAIL nochk_rd13: got %0h want %0h", rd_data, exp_v); end
    rd_addr = AW'(15); exp_q.push_back(pat(14, 4)); tick(1'b0, 1'b0);
    exp_v = exp_q.pop_front();
    n_chk++; if (rd_data !== exp_v) begin n_fail++; $display("FAIL nochk_rd15: got %0h want %0h", rd_data, exp_v); end
`endif
    cen = 1'b0;
    snap_req = 1'b0;
  endtask

  task automatic test_small();
    int c8;
    int n;
    bit counting;
    bit start;
    bit seen;
    int sl[2] = '{0, 7};
    cen8 = 1'b1; cnt8 = 3'd2; mixed8 = 10'h155;
    @(posedge clk); #1;
    n_chk++; if (live8[0 +: W] !== 10'h155 || live8[W +: W] !== '0) begin
      n_fail++; $display("FAIL s8_live0: got %0h slot1 %0h want 155 0", live8[0 +: W], live8[W +: W]); end
    cen8 = 1'b0; req8 = 1'b1;
    @(posedge clk); #1;
    req8 = 1'b0;
    n_chk++; if (busy8 !== 1'b1) begin n_fail++; $display("FAIL s8_arm: got %b want 1", busy8); end
    c8 = 3; n = 0; counting = 1'b0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cen8 = 1'b1; cnt8 = 3'(c8); mixed8 = W'(c8 * 5 + 1);
      start = !counting && busy8 && ((c8 + 6) % 8 == 0);
      @(posedge clk); #1;
      if (start) counting = 1'b1;
      if (counting) n++;
      c8 = (c8 + 1) % 8;
      if (done8) begin seen = 1'b1; break; end
    end
    cen8 = 1'b0;
    n_chk++; if (!seen || n !== 8) begin n_fail++; $display("FAIL s8_done: got seen %b cen %0d want 1 8", seen, n); end
    foreach (sl[i]) begin
      rd_addr8 = 3'(sl[i]);
      exp_q.push_back(W'(((sl[i] + 2) % 8) * 5 + 1));
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      n_chk++; if (rd_data8 !== exp_v) begin
        n_fail++; $display("FAIL s8_rd%0d: got %0h want %0h", sl[i], rd_data8, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_live();
    test_snapshot();
    test_abort();
    test_cen_toggle();
    test_chk();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
